gpr_wb_arbiter: RTL and testbench



---
 rtl/gpr_wb_arbiter_pkg.sv | 11 +
 rtl/gpr_wb_arbiter_scoreboard.sv | 39 +++
 rtl/gpr_wb_arbiter.sv | 97 +++++++++
 tb/tb_gpr_wb_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// gpr_wb_arbiter_pkg: shared sizes and source encoding for the GPR writeback arbiter.
package gpr_wb_arbiter_pkg;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;
endpackage

// File: rtl/gpr_wb_arbiter_scoreboard.sv
// gpr_scoreboard: per-register busy bits with issue-side set, writeback-side clear and two decode queries.
module gpr_scoreboard
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_i,
    input  logic [AW-1:0] set_reg_i,
    input  logic          clr_i,
    input  logic [AW-1:0] clr_reg_i,
    input  logic [AW-1:0] iss_reg_i,
    input  logic [AW-1:0] rs_addr_i,
    input  logic [AW-1:0] rt_addr_i,
    output logic          iss_ready_o,
    output logic          rs_busy_o,
    output logic          rt_busy_o
);
    logic [NREG-1:0] busy_q, busy_d;

    // Set is applied after clear so a same-edge set/clear on one register leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_reg_i] = 1'b0;
        if (set_i) busy_d[set_reg_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign iss_ready_o = !busy_q[iss_reg_i] || iss_reg_i == '0;
    assign rs_busy_o   = busy_q[rs_addr_i];
    assign rt_busy_o   = busy_q[rt_addr_i];
endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin ALU/load arbitration onto the single GPR write port plus busy scoreboard.
// Define GPR_WB_FWD_EN to add rs_fwd/rt_fwd/fwd_data bypass outputs for the write cycle.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_reg,
    output logic          iss_ready,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic          rs_busy,
    output logic          rt_busy,
    input  logic          a_valid,
    input  logic [AW-1:0] a_reg,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          m_valid,
    input  logic [AW-1:0] m_reg,
    input  logic [DW-1:0] m_data,
    output logic          m_ready,
    output logic          gpr_we,
    output logic [AW-1:0] gpr_waddr,
    output logic [DW-1:0] gpr_wdata
`ifdef GPR_WB_FWD_EN
    ,
    output logic          rs_fwd,
    output logic          rt_fwd,
    output logic [DW-1:0] fwd_data
`endif
);
    src_e          rr_q, rr_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          grant;
    logic [AW-1:0] g_reg;
    logic [DW-1:0] g_data;

    assign a_ready = a_valid && (!m_valid || rr_q == SRC_ALU);
    assign m_ready = m_valid && (!a_valid || rr_q == SRC_MEM);
    assign grant   = a_ready || m_ready;
    assign g_reg   = a_ready ? a_reg : m_reg;
    assign g_data  = a_ready ? a_data : m_data;

    // Only contested grants move the pointer; writes to reg 0 are granted but dropped.
    always_comb begin
        rr_d    = (a_valid && m_valid) ? (rr_q == SRC_ALU ? SRC_MEM : SRC_ALU) : rr_q;
        we_d    = grant && g_reg != '0;
        waddr_d = grant ? g_reg : waddr_q;
        wdata_d = grant ? g_data : wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= SRC_ALU;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign gpr_we    = we_q;
    assign gpr_waddr = waddr_q;
    assign gpr_wdata = wdata_q;

    gpr_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_i       (iss_valid && iss_ready),
        .set_reg_i   (iss_reg),
        .clr_i       (grant),
        .clr_reg_i   (g_reg),
        .iss_reg_i   (iss_reg),
        .rs_addr_i   (rs_addr),
        .rt_addr_i   (rt_addr),
        .iss_ready_o (iss_ready),
        .rs_busy_o   (rs_busy),
        .rt_busy_o   (rt_busy)
    );

`ifdef GPR_WB_FWD_EN
    assign rs_fwd   = we_q && waddr_q == rs_addr && rs_addr != '0;
    assign rt_fwd   = we_q && waddr_q == rt_addr && rt_addr != '0;
    assign fwd_data = wdata_q;
`endif
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed stimulus with a write-port scoreboard queue drained by a monitor.
module tb_gpr_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_reg, rs_addr, rt_addr;
    logic        rs_busy, rt_busy;
    logic        a_valid, a_ready, m_valid, m_ready;
    logic [4:0]  a_reg, m_reg;
    logic [31:0] a_data, m_data;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
`ifdef GPR_WB_FWD_EN
    logic        rs_fwd, rt_fwd;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    gpr_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_ready(iss_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_reg(m_reg), .m_data(m_data), .m_ready(m_ready),
        .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata)
`ifdef GPR_WB_FWD_EN
        , .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .fwd_data(fwd_data)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Every write-port pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && gpr_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, gpr_waddr}, 32'hDEAD);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {27'd0, gpr_waddr}, {27'd0, e[36:32]});
                check("wr_data", gpr_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        {iss_valid, a_valid, m_valid} = '0;
        {iss_reg, rs_addr, rt_addr, a_reg, m_reg} = '0;
        {a_data, m_data} = '0;
        tick(); tick();
        @(negedge clk);
        check("rst_we", {31'd0, gpr_we}, 0);
        check("rst_waddr", {27'd0, gpr_waddr}, 0);
        check("rst_wdata", gpr_wdata, 0);
        check("rst_iss_ready", {31'd0, iss_ready}, 1);
        tick(); rst_n = 1'b1;

        // ALU write to issued reg 5
        iss_valid = 1; iss_reg = 5; rs_addr = 5;
        @(negedge clk);
        check("t1_iss_ready", {31'd0, iss_ready}, 1);
        check("t1_busy_pre", {31'd0, rs_busy}, 0);
        tick(); iss_valid = 0; a_valid = 1; a_reg = 5; a_data = 32'h1234;
        @(negedge clk);
        check("t1_busy_set", {31'd0, rs_busy}, 1);
        check("t1_a_ready", {31'd0, a_ready}, 1);
        push(5, 32'h1234);
        tick(); a_valid = 0;
        @(negedge clk);
        check("t1_busy_clr", {31'd0, rs_busy}, 0);

        // Contested round robin
        tick(); a_valid = 1; a_reg = 3; a_data = 32'hA; m_valid = 1; m_reg = 4; m_data = 32'hB;
        @(negedge clk);
        check("t2_a_ready1", {31'd0, a_ready}, 1);
        check("t2_m_ready1", {31'd0, m_ready}, 0);
        push(3, 32'hA);
        tick();
        @(negedge clk);
        check("t2_a_ready2", {31'd0, a_ready}, 0);
        check("t2_m_ready2", {31'd0, m_ready}, 1);
        push(4, 32'hB);
        tick(); m_valid = 0; a_data = 32'hC;
        @(negedge clk);
        check("t2_a_alone", {31'd0, a_ready}, 1);
        push(3, 32'hC);
        tick(); a_reg = 8; a_data = 32'hD; m_valid = 1; m_reg = 4; m_data = 32'hE;
        @(negedge clk);
        check("t2_a_ready3", {31'd0, a_ready}, 1);
        check("t2_m_ready3", {31'd0, m_ready}, 0);
        push(8, 32'hD);
        tick(); a_valid = 0;
        @(negedge clk);
        check("t2_m_after", {31'd0, m_ready}, 1);
        push(4, 32'hE);
        tick(); m_valid = 0;

        // WAW stall on reg 7, then same-edge set and clear
        iss_valid = 1; iss_reg = 7; rs_addr = 7;
        @(negedge clk);
        check("t3_iss1", {31'd0, iss_ready}, 1);
        tick();
        @(negedge clk);
        check("t3_iss_stall", {31'd0, iss_ready}, 0);
        check("t3_busy", {31'd0, rs_busy}, 1);
        tick(); a_valid = 1; a_reg = 7; a_data = 32'h77;
        @(negedge clk);
        check("t3_iss_grant_cyc", {31'd0, iss_ready}, 0);
        check("t3_a_ready", {31'd0, a_ready}, 1);
        push(7, 32'h77);
        tick(); a_data = 32'h78;
        @(negedge clk);
        check("t3_iss_reissue", {31'd0, iss_ready}, 1);
        push(7, 32'h78);
        tick(); iss_valid = 0; a_valid = 0;
        @(negedge clk);
        check("t3_set_wins", {31'd0, rs_busy}, 1);
        tick(); a_valid = 1; a_data = 32'h79;
        push(7, 32'h79);
        tick(); a_valid = 0;
        @(negedge clk);
        check("t3_busy_final", {31'd0, rs_busy}, 0);

        // Reg 0 write and issue
        m_valid = 1; m_reg = 0; m_data = 32'hFFFF_FFFF; rs_addr = 0; iss_valid = 1; iss_reg = 0;
        @(negedge clk);
        check("t4_m_ready", {31'd0, m_ready}, 1);
        check("t4_iss_ready", {31'd0, iss_ready}, 1);
        check("t4_busy0", {31'd0, rs_busy}, 0);
        tick(); m_valid = 0; iss_valid = 0;
        @(negedge clk);
        check("t4_no_we", {31'd0, gpr_we}, 0);
        check("t4_busy0_after", {31'd0, rs_busy}, 0);

        // Reset between grant and write
        tick(); iss_valid = 1; iss_reg = 9; a_valid = 1; a_reg = 10; a_data = 32'h10; rs_addr = 9;
        push(10, 32'h10);
        tick(); iss_valid = 0; a_reg = 9; a_data = 32'h99;
        @(negedge clk);
        check("t5_a_ready", {31'd0, a_ready}, 1);
        check("t5_busy9", {31'd0, rs_busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_we_rst", {31'd0, gpr_we}, 0);
        check("t5_busy9_rst", {31'd0, rs_busy}, 0);
        tick(); a_valid = 0;
        tick(); rst_n = 1'b1;
        @(negedge clk);
        check("t5_we_after", {31'd0, gpr_we}, 0);

`ifdef GPR_WB_FWD_EN
        tick(); a_valid = 1; a_reg = 6; a_data = 32'h55;
        push(6, 32'h55);
        tick(); a_valid = 0; rs_addr = 6; rt_addr = 0;
        @(negedge clk);
        check("fwd_rs", {31'd0, rs_fwd}, 1);
        check("fwd_rt", {31'd0, rt_fwd}, 0);
        check("fwd_data", fwd_data, 32'h55);
`endif

        tick(); tick();
        check("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
